// File: rtl/clock_display_mux.sv
// Six-digit multiplexed seven-segment driver for the 24-hour clock counter.
// Snapshots the BCD time once per frame and scans it onto a shared segment bus.
module clock_display_mux #(
    parameter int REFRESH_DIV   = 1000,
    parameter int GUARD         = 2,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sec_units,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min_units,
    input  logic [3:0] min_tens,
    input  logic [3:0] hour_units,
    input  logic [1:0] hour_tens,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       dp,
    output logic       frame_start,
    output logic       err
);

    localparam int              PC_W    = $clog2(REFRESH_DIV);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(REFRESH_DIV - 1);
    localparam logic [PC_W-1:0] PC_ON   = PC_W'(GUARD);

    logic [PC_W-1:0] pc;
    logic [2:0]      idx;
    logic            running;
    logic [3:0]      sh_su, sh_st, sh_mu, sh_mt, sh_hu;
    logic [1:0]      sh_ht;

    logic       snap;
    logic [5:0] hour_val;
    logic       hour_bad;
    logic [5:0] bad;
    logic [3:0] digit;
    logic       digit_bad;
    logic [6:0] seg_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    // The cycle after reset is a pre-frame: it forces a snapshot and parks the scan at slot 0.
    assign snap = !running || (pc == PC_LAST && idx == 3'd5);

    assign hour_val = 6'(sh_ht) * 6'd10 + 6'(sh_hu);
    assign hour_bad = hour_val > 6'd23;

    always_comb begin
        bad[0] = sh_su > 4'd9;
        bad[1] = sh_st > 4'd5;
        bad[2] = sh_mu > 4'd9;
        bad[3] = sh_mt > 4'd5;
        bad[4] = (sh_hu > 4'd9) || hour_bad;
        bad[5] = (sh_ht == 2'd3) || hour_bad;
    end

    always_comb begin
        digit     = 4'd0;
        digit_bad = 1'b0;
        case (idx)
            3'd0:    begin digit = sh_su;         digit_bad = bad[0]; end
            3'd1:    begin digit = sh_st;         digit_bad = bad[1]; end
            3'd2:    begin digit = sh_mu;         digit_bad = bad[2]; end
            3'd3:    begin digit = sh_mt;         digit_bad = bad[3]; end
            3'd4:    begin digit = sh_hu;         digit_bad = bad[4]; end
            3'd5:    begin digit = {2'b00, sh_ht}; digit_bad = bad[5]; end
            default: begin digit = 4'd0;          digit_bad = 1'b0;   end
        endcase
        if (digit_bad)
            seg_next = 7'h40;
        else if (BLANK_LEADING && idx == 3'd5 && sh_ht == 2'd0)
            seg_next = 7'h00;
        else
            seg_next = decode(digit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= '0;
            idx         <= 3'd0;
            running     <= 1'b0;
            sh_su       <= 4'd0;
            sh_st       <= 4'd0;
            sh_mu       <= 4'd0;
            sh_mt       <= 4'd0;
            sh_hu       <= 4'd0;
            sh_ht       <= 2'd0;
            seg         <= 7'h00;
            an          <= 6'b0;
            dp          <= 1'b0;
            frame_start <= 1'b0;
            err         <= 1'b0;
        end else begin
            running     <= 1'b1;
            frame_start <= snap;
            if (snap) begin
                sh_su <= sec_units;
                sh_st <= sec_tens;
                sh_mu <= min_units;
                sh_mt <= min_tens;
                sh_hu <= hour_units;
                sh_ht <= hour_tens;
            end
            if (!running) begin
                pc  <= '0;
                idx <= 3'd0;
            end else if (pc == PC_LAST) begin
                pc  <= '0;
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                pc <= pc + 1'b1;
            end
            // Outputs describe the slot of the current cycle, hence one cycle of latency.
            seg <= running ? seg_next : 7'h00;
            an  <= (running && pc >= PC_ON) ? (6'd1 << idx) : 6'b0;
            dp  <= running && (idx == 3'd2 || idx == 3'd4) && !sh_su[0];
            err <= running && (|bad);
        end
    end

endmodule

// File: tb/tb_clock_display_mux.sv
// Randomized self-checking bench for clock_display_mux against a frame/slot arithmetic model.
module tb_clock_display_mux;

    localparam int DIV   = 4;
    localparam int GRD   = 1;
    localparam int FRAME = 6 * DIV;

    typedef logic [3:0] digits_t [6];

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sec_units, sec_tens, min_units, min_tens, hour_units;
    logic [1:0] hour_tens;
    logic [6:0] seg, seg_nb;
    logic [5:0] an, an_nb;
    logic       dp, dp_nb, frame_start, fs_nb, err, err_nb;

    int      checks = 0;
    int      fails  = 0;
    int      edge_n = 0;
    int      last_slot = -1;
    logic    last_fs = 1'b0;
    digits_t model_shadow = '{default: 4'd0};
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    clock_display_mux #(.REFRESH_DIV(DIV), .GUARD(GRD), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .reset(reset),
        .sec_units(sec_units), .sec_tens(sec_tens),
        .min_units(min_units), .min_tens(min_tens),
        .hour_units(hour_units), .hour_tens(hour_tens),
        .seg(seg), .an(an), .dp(dp), .frame_start(frame_start), .err(err)
    );

    clock_display_mux #(.REFRESH_DIV(DIV), .GUARD(GRD), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .reset(reset),
        .sec_units(sec_units), .sec_tens(sec_tens),
        .min_units(min_units), .min_tens(min_tens),
        .hour_units(hour_units), .hour_tens(hour_tens),
        .seg(seg_nb), .an(an_nb), .dp(dp_nb), .frame_start(fs_nb), .err(err_nb)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", tag, observed, expected, edge_n);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] su, input logic [3:0] st, input logic [3:0] mu,
                                 input logic [3:0] mt, input logic [3:0] hu, input logic [1:0] ht);
        sec_units  = su;
        sec_tens   = st;
        min_units  = mu;
        min_tens   = mt;
        hour_units = hu;
        hour_tens  = ht;
    endtask

    task automatic setTime(input int h, input int m, input int s);
        applyStimulus(4'(s % 10), 4'(s / 10), 4'(m % 10), 4'(m / 10), 4'(h % 10), 2'(h / 10));
    endtask

    // Digit validity from the time-of-day rules: seconds/minutes 00..59, hours 00..23.
    function automatic logic digitBad(input int slot, input digits_t d);
        int hour;
        hour = int'(d[5]) * 10 + int'(d[4]);
        case (slot)
            0, 2:    return d[slot] > 9;
            1, 3:    return d[slot] > 5;
            4:       return d[4] > 9 || hour > 23;
            default: return d[5] == 3 || hour > 23;
        endcase
    endfunction

    task automatic checkZeros(input string tag);
        checkOutput({tag, ".seg"}, 32'(seg), 32'h0);
        checkOutput({tag, ".an"}, 32'(an), 32'h0);
        checkOutput({tag, ".dp"}, 32'(dp), 32'h0);
        checkOutput({tag, ".fs"}, 32'(frame_start), 32'h0);
        checkOutput({tag, ".err"}, 32'(err), 32'h0);
        checkOutput({tag, ".seg_nb"}, 32'(seg_nb), 32'h0);
    endtask

    task automatic stepCycle();
        digits_t    used;
        int         p, slot, pcv;
        logic [6:0] exp_seg, exp_seg_nb;
        logic [5:0] exp_an;
        logic       exp_dp, exp_err, exp_fs;
        used = model_shadow;
        @(posedge clk);
        edge_n++;
        exp_fs = ((edge_n - 1) % FRAME) == 0;
        if (exp_fs)
            model_shadow = '{sec_units, sec_tens, min_units, min_tens, hour_units, {2'b00, hour_tens}};
        #1;
        exp_seg = 7'h00; exp_seg_nb = 7'h00; exp_an = 6'b0; exp_dp = 1'b0; exp_err = 1'b0;
        slot = -1;
        if (edge_n >= 2) begin
            p    = (edge_n - 2) % FRAME;
            slot = p / DIV;
            pcv  = p % DIV;
            for (int i = 0; i < 6; i++)
                if (digitBad(i, used)) exp_err = 1'b1;
            exp_seg    = digitBad(slot, used) ? 7'h40 : seg_tab[used[slot]];
            exp_seg_nb = exp_seg;
            if (slot == 5 && used[5] == 4'd0) exp_seg = 7'h00;
            exp_an = (pcv >= GRD) ? 6'(1 << slot) : 6'b0;
            exp_dp = (slot == 2 || slot == 4) && !used[0][0];
        end
        last_slot = slot;
        last_fs   = exp_fs;
        checkOutput("seg", 32'(seg), 32'(exp_seg));
        checkOutput("seg_noblank", 32'(seg_nb), 32'(exp_seg_nb));
        checkOutput("an", 32'(an), 32'(exp_an));
        checkOutput("dp", 32'(dp), 32'(exp_dp));
        checkOutput("err", 32'(err), 32'(exp_err));
        checkOutput("frame_start", 32'(frame_start), 32'(exp_fs));
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    // Waits for a fresh frame, then for the first output cycle of the given slot.
    task automatic waitSlot(input int s);
        int   budget;
        logic seen_fs;
        budget  = 3 * FRAME;
        seen_fs = 1'b0;
        while (budget > 0 && !(seen_fs && last_slot == s)) begin
            stepCycle();
            if (last_fs) seen_fs = 1'b1;
            budget--;
        end
        checkOutput("wait_slot_timeout", 32'(budget > 0), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        setTime(12, 34, 56);
        repeat (5) begin
            @(posedge clk);
            #1;
            checkZeros("reset");
        end
        reset  = 1'b1;
        edge_n = 0;
        runCycles(2 * FRAME + 2);

        setTime(9, 0, 0);
        runCycles(2 * FRAME);

        setTime(12, 34, 59);
        waitSlot(2);
        setTime(12, 35, 0);
        runCycles(2 * FRAME);

        applyStimulus(4'd0, 4'd0, 4'd0, 4'd6, 4'd2, 2'd1);
        runCycles(2 * FRAME);
        setTime(12, 0, 0);
        runCycles(2 * FRAME);
        applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 2'd2);
        runCycles(2 * FRAME);

        setTime(1, 2, 4);
        runCycles(2 * FRAME);
        setTime(1, 2, 5);
        runCycles(2 * FRAME);

        repeat (20) begin
            if ($urandom_range(0, 1) == 0)
                setTime(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
            else
                applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            runCycles(int'($urandom_range(5, 40)));
        end

        setTime(23, 59, 58);
        waitSlot(3);
        #2;
        reset = 1'b0;
        #1;
        checkZeros("midframe_reset");
        repeat (3) begin
            @(posedge clk);
            #1;
            checkZeros("reset_hold");
        end
        reset        = 1'b1;
        edge_n       = 0;
        model_shadow = '{default: 4'd0};
        setTime(7, 45, 30);
        runCycles(FRAME + 4);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
